// File: rtl/tpu_isa_pkg.sv
// ============================================================================
//  Module   : tpu_isa_pkg
//  Purpose  : Shared TPU ISA definitions: unit codes, field map, instruction
//             struct and dispatch state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_isa_pkg;

    localparam int c_isa_instr_w  = 128;
    localparam int c_isa_addr_w   = 13;

    localparam int c_unit_lsb       = 126;
    localparam int c_unit_w         = 2;
    localparam int c_addr_a_lsb     = 113;
    localparam int c_addr_b_lsb     = 100;
    localparam int c_addr_out_lsb   = 87;
    localparam int c_addr_const_lsb = 74;
    localparam int c_opcode_lsb     = 64;
    localparam int c_opcode_w       = 10;
    localparam int c_len_lsb        = 41;
    localparam int c_len_w          = 23;
    localparam int c_vpu_type_lsb   = 38;
    localparam int c_vreg_dst_lsb   = 35;
    localparam int c_vreg_a_lsb     = 32;
    localparam int c_vreg_b_lsb     = 29;
    localparam int c_vpu_opcode_lsb = 26;
    localparam int c_vfield_w       = 3;
    localparam int c_scalar_b_bit   = 25;
    localparam int c_reserved_w     = 25;

    localparam logic [1:0] c_mode_idle = 2'b11;

    typedef enum logic [1:0] {
        UNIT_VPU      = 2'b00,
        UNIT_SYSTOLIC = 2'b01,
        UNIT_VADD     = 2'b10,
        UNIT_HALT     = 2'b11
    } unit_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    // Field order mirrors the instruction word from MSB down.
    typedef struct packed {
        unit_e                     unit;
        logic [c_isa_addr_w-1:0]   addr_a;
        logic [c_isa_addr_w-1:0]   addr_b;
        logic [c_isa_addr_w-1:0]   addr_out;
        logic [c_isa_addr_w-1:0]   addr_const;
        logic [c_opcode_w-1:0]     opcode;
        logic [c_len_w-1:0]        len;
        logic [c_vfield_w-1:0]     vpu_type;
        logic [c_vfield_w-1:0]     vreg_dst;
        logic [c_vfield_w-1:0]     vreg_a;
        logic [c_vfield_w-1:0]     vreg_b;
        logic [c_vfield_w-1:0]     vpu_opcode;
        logic                      scalar_b;
        logic [c_reserved_w-1:0]   reserved;
    } instr_t;

    function automatic logic [2:0] unit_onehot(input unit_e u);
        unit_onehot = 3'b000;
        case (u)
            UNIT_VPU:      unit_onehot = 3'b100;
            UNIT_SYSTOLIC: unit_onehot = 3'b010;
            UNIT_VADD:     unit_onehot = 3'b001;
            default:       unit_onehot = 3'b000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/compute_dispatch.sv
// ============================================================================
//  Module   : compute_dispatch
//  Purpose  : Accepts TPU instructions, issues a one-cycle start to the target
//             unit, holds its operands until done, with halt/error handling.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module compute_dispatch
    import tpu_isa_pkg::*;
#(
    parameter int ADDR_WIDTH     = 13,
    parameter int INSTR_WIDTH    = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic                   instr_ready,
    input  logic                   resume,
    input  logic                   clear_err,
    output logic [1:0]             mode_compute,
    output logic [ADDR_WIDTH-1:0]  addr_a_compute,
    output logic [ADDR_WIDTH-1:0]  addr_b_compute,
    output logic [ADDR_WIDTH-1:0]  addr_out_compute,
    output logic [ADDR_WIDTH-1:0]  addr_const_compute,
    output logic [9:0]             opcode_compute,
    output logic [22:0]            len_compute,
    output logic [2:0]             vpu_type_compute,
    output logic [2:0]             vreg_dst_compute,
    output logic [2:0]             vreg_a_compute,
    output logic [2:0]             vreg_b_compute,
    output logic [2:0]             vpu_opcode_compute,
    output logic                   scalar_b_compute,
    output logic                   start_vpu_compute,
    output logic                   start_systolic_compute,
    output logic                   start_vadd_compute,
    input  logic                   vpu_done_compute,
    input  logic                   systolic_done_compute,
    input  logic                   vadd_done_compute,
    output logic                   busy,
    output logic                   halted,
    output logic                   error,
    output logic [15:0]            retired_count
);

    // Counter only needs to reach TIMEOUT_CYCLES-1 before the trip compare.
    localparam int c_wd_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e              r_state;
    unit_e               r_unit;
    logic [c_wd_w-1:0]   r_wdog;

    instr_t              w_instr;
    logic                w_accept;
    logic                w_active_done;
    logic                w_timeout;
    logic [2:0]          w_start;
    logic                w_unused_reserved;

    assign w_instr           = instr_t'(instr_data[c_isa_instr_w-1:0]);
    assign w_unused_reserved = ^w_instr.reserved;
    assign instr_ready       = (r_state == ST_IDLE);
    assign w_accept          = instr_valid & instr_ready;
    assign w_start           = unit_onehot(w_instr.unit);
    assign w_timeout         = (TIMEOUT_CYCLES != 0) &&
                               (r_wdog == c_wd_w'(TIMEOUT_CYCLES - 1));

    // Only the unit that was issued can complete the instruction.
    always_comb begin
        w_active_done = 1'b0;
        case (r_unit)
            UNIT_VPU:      w_active_done = vpu_done_compute;
            UNIT_SYSTOLIC: w_active_done = systolic_done_compute;
            UNIT_VADD:     w_active_done = vadd_done_compute;
            default:       w_active_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                <= ST_IDLE;
            r_unit                 <= UNIT_VPU;
            r_wdog                 <= '0;
            mode_compute           <= c_mode_idle;
            addr_a_compute         <= '0;
            addr_b_compute         <= '0;
            addr_out_compute       <= '0;
            addr_const_compute     <= '0;
            opcode_compute         <= '0;
            len_compute            <= '0;
            vpu_type_compute       <= '0;
            vreg_dst_compute       <= '0;
            vreg_a_compute         <= '0;
            vreg_b_compute         <= '0;
            vpu_opcode_compute     <= '0;
            scalar_b_compute       <= 1'b0;
            start_vpu_compute      <= 1'b0;
            start_systolic_compute <= 1'b0;
            start_vadd_compute     <= 1'b0;
            busy                   <= 1'b0;
            halted                 <= 1'b0;
            error                  <= 1'b0;
            retired_count          <= '0;
        end else begin
            start_vpu_compute      <= 1'b0;
            start_systolic_compute <= 1'b0;
            start_vadd_compute     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_instr.unit == UNIT_HALT) begin
                            r_state       <= ST_HALT;
                            halted        <= 1'b1;
                            retired_count <= retired_count + 16'd1;
                        end else begin
                            r_state                <= ST_ISSUE;
                            r_unit                 <= w_instr.unit;
                            mode_compute           <= w_instr.unit;
                            busy                   <= 1'b1;
                            {start_vpu_compute, start_systolic_compute,
                             start_vadd_compute}   <= w_start;
                            addr_a_compute         <= ADDR_WIDTH'(w_instr.addr_a);
                            addr_b_compute         <= ADDR_WIDTH'(w_instr.addr_b);
                            addr_out_compute       <= ADDR_WIDTH'(w_instr.addr_out);
                            addr_const_compute     <= ADDR_WIDTH'(w_instr.addr_const);
                            opcode_compute         <= w_instr.opcode;
                            len_compute            <= w_instr.len;
                            vpu_type_compute       <= w_instr.vpu_type;
                            vreg_dst_compute       <= w_instr.vreg_dst;
                            vreg_a_compute         <= w_instr.vreg_a;
                            vreg_b_compute         <= w_instr.vreg_b;
                            vpu_opcode_compute     <= w_instr.vpu_opcode;
                            scalar_b_compute       <= w_instr.scalar_b;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_wdog  <= '0;
                end
                ST_WAIT: begin
                    // Done takes priority over a watchdog trip in the same cycle.
                    if (w_active_done) begin
                        r_state       <= ST_IDLE;
                        busy          <= 1'b0;
                        mode_compute  <= c_mode_idle;
                        retired_count <= retired_count + 16'd1;
                    end else if (w_timeout) begin
                        r_state      <= ST_ERROR;
                        busy         <= 1'b0;
                        error        <= 1'b1;
                        mode_compute <= c_mode_idle;
                    end else begin
                        r_wdog <= r_wdog + c_wd_w'(1);
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        r_state <= ST_IDLE;
                        halted  <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (clear_err) begin
                        r_state <= ST_IDLE;
                        error   <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    busy         <= 1'b0;
                    halted       <= 1'b0;
                    error        <= 1'b0;
                    mode_compute <= c_mode_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_compute_dispatch.sv
// ============================================================================
//  Module   : tb_compute_dispatch
//  Purpose  : Self-checking bench for compute_dispatch (default and short
//             watchdog instances) using an expected-instruction scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compute_dispatch;
    import tpu_isa_pkg::*;

    typedef struct packed {
        logic [1:0]  unit;
        logic [12:0] a, b, o, c;
        logic [9:0]  op;
        logic [22:0] len;
        logic [2:0]  vt, vd, va, vb, vo;
        logic        sb;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         instr_valid;
    logic [127:0] instr_data;
    logic         resume, clear_err;
    logic [2:0]   dones;
    wire          vpu_done = dones[2];
    wire          sys_done = dones[1];
    wire          vadd_done = dones[0];

    wire          instr_ready, busy, halted, error;
    wire  [1:0]   mode;
    wire  [12:0]  addr_a, addr_b, addr_out, addr_const;
    wire  [9:0]   opcode;
    wire  [22:0]  len;
    wire  [2:0]   vpu_type, vreg_dst, vreg_a, vreg_b, vpu_opcode;
    wire          scalar_b, st_vpu, st_sys, st_vadd;
    wire  [15:0]  retired;

    wire          t_instr_ready, t_busy, t_halted, t_error;
    wire  [1:0]   t_mode;
    wire  [12:0]  t_addr_a, t_addr_b, t_addr_out, t_addr_const;
    wire  [9:0]   t_opcode;
    wire  [22:0]  t_len;
    wire  [2:0]   t_vpu_type, t_vreg_dst, t_vreg_a, t_vreg_b, t_vpu_opcode;
    wire          t_scalar_b, t_st_vpu, t_st_sys, t_st_vadd;
    wire  [15:0]  t_retired;

    wire  [2:0]   starts = {st_vpu, st_sys, st_vadd};
    wire  [100:0] obs_fields = {addr_a, addr_b, addr_out, addr_const, opcode, len,
                                vpu_type, vreg_dst, vreg_a, vreg_b, vpu_opcode, scalar_b};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_ret = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    compute_dispatch dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_ready(instr_ready), .resume(resume), .clear_err(clear_err),
        .mode_compute(mode), .addr_a_compute(addr_a), .addr_b_compute(addr_b),
        .addr_out_compute(addr_out), .addr_const_compute(addr_const),
        .opcode_compute(opcode), .len_compute(len), .vpu_type_compute(vpu_type),
        .vreg_dst_compute(vreg_dst), .vreg_a_compute(vreg_a), .vreg_b_compute(vreg_b),
        .vpu_opcode_compute(vpu_opcode), .scalar_b_compute(scalar_b),
        .start_vpu_compute(st_vpu), .start_systolic_compute(st_sys),
        .start_vadd_compute(st_vadd), .vpu_done_compute(vpu_done),
        .systolic_done_compute(sys_done), .vadd_done_compute(vadd_done),
        .busy(busy), .halted(halted), .error(error), .retired_count(retired)
    );

    compute_dispatch #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_ready(t_instr_ready), .resume(resume), .clear_err(clear_err),
        .mode_compute(t_mode), .addr_a_compute(t_addr_a), .addr_b_compute(t_addr_b),
        .addr_out_compute(t_addr_out), .addr_const_compute(t_addr_const),
        .opcode_compute(t_opcode), .len_compute(t_len), .vpu_type_compute(t_vpu_type),
        .vreg_dst_compute(t_vreg_dst), .vreg_a_compute(t_vreg_a), .vreg_b_compute(t_vreg_b),
        .vpu_opcode_compute(t_vpu_opcode), .scalar_b_compute(t_scalar_b),
        .start_vpu_compute(t_st_vpu), .start_systolic_compute(t_st_sys),
        .start_vadd_compute(t_st_vadd), .vpu_done_compute(vpu_done),
        .systolic_done_compute(sys_done), .vadd_done_compute(vadd_done),
        .busy(t_busy), .halted(t_halted), .error(t_error), .retired_count(t_retired)
    );

    function automatic exp_t rand_exp(input logic [1:0] u);
        logic [127:0] r;
        exp_t         e;
        r = {$urandom, $urandom, $urandom, $urandom};
        e = r[102:0];
        e.unit = u;
        return e;
    endfunction

    function automatic logic [127:0] make_instr(input exp_t e);
        logic [31:0] r;
        r = $urandom;
        return {e, r[24:0]};
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] u);
        case (u)
            2'b00:   return 3'b100;
            2'b01:   return 3'b010;
            2'b10:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0;
        resume = 1'b0; clear_err = 1'b0; dones = 3'b000;
        model_ret = 0;
        sb_q.delete();
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    // Presents an instruction and returns in the cycle after the accept edge.
    task automatic accept(input exp_t e);
        int waited;
        waited = 0;
        if (e.unit != 2'b11) sb_q.push_back(e);
        instr_data  = make_instr(e);
        instr_valid = 1'b1;
        while (!instr_ready && waited < 50) begin
            tick;
            waited++;
        end
        if (!instr_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: instr_ready got %b want 1", instr_ready);
        end
        tick;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0;
        resume = 1'b0; clear_err = 1'b0; dones = 3'b000;
        #23;
        n_cmp++;
        if ({mode, starts, busy, halted, error, retired} !== {2'b11, 3'b000, 3'b000, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_ctrl: got mode=%b st=%b b/h/e=%b%b%b ret=%0d want 11 000 000 0",
                     mode, starts, busy, halted, error, retired);
        end
        n_cmp++;
        if (obs_fields !== 101'd0) begin
            n_bad++;
            $display("FAIL reset_fields: got %h want 0", obs_fields);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
    endtask

    task automatic test_vpu;
        exp_t e, g;
        logic held_ok;
        e = rand_exp(2'b00);
        e.a = 13'h010; e.b = 13'h020; e.o = 13'h030;
        repeat (2) tick;
        accept(e);
        g = sb_q.pop_front();
        n_cmp++;
        if ({starts, busy, mode} !== {3'b100, 1'b1, 2'b00}) begin
            n_bad++;
            $display("FAIL vpu_issue: got st=%b busy=%b mode=%b want 100 1 00", starts, busy, mode);
        end
        n_cmp++;
        if (obs_fields !== g[100:0]) begin
            n_bad++;
            $display("FAIL vpu_fields: got %h want %h", obs_fields, g[100:0]);
        end
        tick;
        n_cmp++;
        if (starts !== 3'b000) begin
            n_bad++;
            $display("FAIL vpu_start_width: got %b want 000", starts);
        end
        held_ok = 1'b1;
        repeat (4) begin
            tick;
            if (mode !== 2'b00 || obs_fields !== g[100:0] || busy !== 1'b1 || starts !== 3'b000)
                held_ok = 1'b0;
        end
        n_cmp++;
        if (held_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL vpu_hold: got %b want 1", held_ok);
        end
        dones = 3'b100;
        tick;
        dones = 3'b000;
        model_ret++;
        n_cmp++;
        if ({mode, busy, retired} !== {2'b11, 1'b0, 16'(model_ret)}) begin
            n_bad++;
            $display("FAIL vpu_retire: got mode=%b busy=%b ret=%0d want 11 0 %0d",
                     mode, busy, retired, model_ret);
        end
    endtask

    task automatic test_systolic;
        exp_t e, g;
        e = rand_exp(2'b01);
        accept(e);
        g = sb_q.pop_front();
        n_cmp++;
        if ({starts, mode, obs_fields} !== {3'b010, 2'b01, g[100:0]}) begin
            n_bad++;
            $display("FAIL sys_issue: got st=%b mode=%b f=%h want 010 01 %h",
                     starts, mode, obs_fields, g[100:0]);
        end
        dones = 3'b010;           // done during ISSUE must be ignored
        tick;
        dones = 3'b101;           // other units' dones during WAIT
        tick;
        dones = 3'b000;
        repeat (3) tick;
        n_cmp++;
        if ({busy, mode, retired} !== {1'b1, 2'b01, 16'(model_ret)}) begin
            n_bad++;
            $display("FAIL sys_ignore: got busy=%b mode=%b ret=%0d want 1 01 %0d",
                     busy, mode, retired, model_ret);
        end
        repeat (15) tick;
        dones = 3'b010;
        tick;
        dones = 3'b000;
        model_ret++;
        n_cmp++;
        if ({busy, mode, instr_ready, retired} !== {1'b0, 2'b11, 1'b1, 16'(model_ret)}) begin
            n_bad++;
            $display("FAIL sys_done: got busy=%b mode=%b rdy=%b ret=%0d want 0 11 1 %0d",
                     busy, mode, instr_ready, retired, model_ret);
        end
    endtask

    task automatic test_halt;
        exp_t h, v, g;
        logic quiet_ok;
        h = rand_exp(2'b11);
        accept(h);
        model_ret++;
        n_cmp++;
        if ({halted, instr_ready, busy, mode, starts, retired} !==
            {1'b1, 1'b0, 1'b0, 2'b11, 3'b000, 16'(model_ret)}) begin
            n_bad++;
            $display("FAIL halt_enter: got h=%b rdy=%b b=%b mode=%b st=%b ret=%0d want 1 0 0 11 000 %0d",
                     halted, instr_ready, busy, mode, starts, retired, model_ret);
        end
        v = rand_exp(2'b00);
        sb_q.push_back(v);
        instr_data  = make_instr(v);
        instr_valid = 1'b1;
        clear_err   = 1'b1;
        quiet_ok    = 1'b1;
        repeat (3) begin
            tick;
            clear_err = 1'b0;
            if (starts !== 3'b000 || halted !== 1'b1 || instr_ready !== 1'b0) quiet_ok = 1'b0;
        end
        n_cmp++;
        if (quiet_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_blocks: got %b want 1", quiet_ok);
        end
        resume = 1'b1;
        tick;
        resume = 1'b0;
        n_cmp++;
        if ({halted, instr_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL halt_resume: got h=%b rdy=%b want 0 1", halted, instr_ready);
        end
        tick;
        instr_valid = 1'b0;
        g = sb_q.pop_front();
        n_cmp++;
        if ({starts, obs_fields} !== {3'b100, g[100:0]}) begin
            n_bad++;
            $display("FAIL halt_then_vpu: got st=%b f=%h want 100 %h", starts, obs_fields, g[100:0]);
        end
        tick;
        dones = 3'b100;
        tick;
        dones = 3'b000;
        model_ret++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            exp_t e, g;
            int   d;
            e = rand_exp(2'(i % 3));
            accept(e);
            g = sb_q.pop_front();
            n_cmp++;
            if ({starts, mode, obs_fields} !== {onehot(g.unit), g.unit, g[100:0]}) begin
                n_bad++;
                $display("FAIL b2b_issue[%0d]: got st=%b mode=%b f=%h want %b %b %h",
                         i, starts, mode, obs_fields, onehot(g.unit), g.unit, g[100:0]);
            end
            tick;
            d = $urandom_range(1, 5);
            repeat (d) begin
                dones = ~onehot(g.unit);
                tick;
            end
            dones = onehot(g.unit);
            tick;
            dones = 3'b000;
            model_ret++;
            n_cmp++;
            if ({busy, mode, retired} !== {1'b0, 2'b11, 16'(model_ret)}) begin
                n_bad++;
                $display("FAIL b2b_retire[%0d]: got busy=%b mode=%b ret=%0d want 0 11 %0d",
                         i, busy, mode, retired, model_ret);
            end
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        logic early_err;
        apply_reset;
        e = rand_exp(2'b00);
        accept(e);
        void'(sb_q.pop_front());
        tick;
        early_err = 1'b0;
        repeat (7) begin
            tick;
            if (t_error !== 1'b0) early_err = 1'b1;
        end
        n_cmp++;
        if (early_err !== 1'b0) begin
            n_bad++;
            $display("FAIL to_early: got %b want 0", early_err);
        end
        tick;
        n_cmp++;
        if ({t_error, t_mode, t_busy, t_retired} !== {1'b1, 2'b11, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL to_trip: got e=%b mode=%b b=%b ret=%0d want 1 11 0 0",
                     t_error, t_mode, t_busy, t_retired);
        end
        dones = 3'b100;
        tick;
        dones  = 3'b000;
        resume = 1'b1;
        tick;
        resume = 1'b0;
        n_cmp++;
        if ({t_error, t_retired, t_instr_ready} !== {1'b1, 16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL to_sticky: got e=%b ret=%0d rdy=%b want 1 0 0", t_error, t_retired, t_instr_ready);
        end
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
        n_cmp++;
        if ({t_error, t_instr_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL to_clear: got e=%b rdy=%b want 0 1", t_error, t_instr_ready);
        end
        e = rand_exp(2'b00);
        accept(e);
        void'(sb_q.pop_front());
        tick;
        repeat (7) tick;
        dones = 3'b100;
        tick;
        dones = 3'b000;
        n_cmp++;
        if ({t_error, t_busy, t_mode, t_retired} !== {1'b0, 1'b0, 2'b11, 16'h0001}) begin
            n_bad++;
            $display("FAIL to_done_wins: got e=%b b=%b mode=%b ret=%0d want 0 0 11 1",
                     t_error, t_busy, t_mode, t_retired);
        end
        apply_reset;
    endtask

    task automatic test_reset_mid_wait;
        exp_t e;
        e = rand_exp(2'b01);
        accept(e);
        void'(sb_q.pop_front());
        repeat (2) tick;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mode, starts, busy, halted, error, retired, obs_fields} !==
            {2'b11, 3'b000, 3'b000, 16'h0000, 101'd0}) begin
            n_bad++;
            $display("FAIL rst_mid_wait: got mode=%b b=%b ret=%0d f=%h want 11 0 0 0",
                     mode, busy, retired, obs_fields);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_ret = 0;
        dones = 3'b010;
        tick;
        dones = 3'b000;
        tick;
        n_cmp++;
        if ({retired, busy, mode, instr_ready} !== {16'h0000, 1'b0, 2'b11, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_late_done: got ret=%0d b=%b mode=%b rdy=%b want 0 0 11 1",
                     retired, busy, mode, instr_ready);
        end
    endtask

    task automatic test_wrap;
        apply_reset;
        instr_data  = make_instr(rand_exp(2'b11));
        instr_valid = 1'b1;
        resume      = 1'b1;
        repeat (131070) tick;
        n_cmp++;
        if ({retired, halted} !== {16'hFFFF, 1'b0}) begin
            n_bad++;
            $display("FAIL wrap_pre: got ret=%h h=%b want ffff 0", retired, halted);
        end
        tick;
        instr_valid = 1'b0;
        n_cmp++;
        if ({retired, halted} !== {16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL wrap_zero: got ret=%h h=%b want 0000 1", retired, halted);
        end
        tick;
        resume = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_vpu;
        test_systolic;
        test_halt;
        test_back_to_back;
        test_timeout;
        test_vpu;
        test_reset_mid_wait;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
